motoro3_pwm_monitor: RTL and testbench
======================================

Name: motoro3_pwm_monitor

Overview:
Measurement side of the motor PWM path. It samples the PWM gate signal driven toward the MOSFET drivers and reports the pulse width and low gap of each pulse. It also reports per-step-window totals: high cycles and pulse count. Three checks feed the motor controller and the regfile: short-pulse (below driver minimum), stuck-high and stuck-low. One instance sits beside each phase's PWM generator.

Parameters:
CW, 16, width of all cycle counters and length outputs
PCW, 8, width of window pulse counter

Ports:
clk  in  1  system clock, 10 MHz; all state on rising edge
rst  in  1  asynchronous, active-high reset
pwm  in  1  PWM gate signal under measurement (generator output, changes on falling edge)
winLast  in  1  one-cycle strobe marking last cycle of a step window
m3r_pwmMinMask  in  12  minimum legal pulse width in cycles; 0 disables check
m3r_stuckMax  in  CW  stuck-level limit in cycles; 0 disables check
pulseLen  out  CW  width of last completed high pulse
pulseGap  out  CW  width of low gap preceding last pulse
pulseValid  out  1  one-cycle strobe: pulseLen/pulseGap updated
shortPulse  out  1  one-cycle strobe with pulseValid when pulseLen < minimum
winHighSum  out  CW  high cycles in last completed window
winPulseCnt  out  PCW  pulses completed in last completed window
winValid  out  1  one-cycle strobe: window outputs updated
stuckHigh  out  1  level: pwm high for >= m3r_stuckMax consecutive samples
stuckLow  out  1  level: pwm low for >= m3r_stuckMax consecutive samples
errSticky  out  1  set by shortPulse, stuckHigh or stuckLow; cleared only by rst

Behaviour:
- Reset values: all outputs 0. FSM is in IDLE. All counters are 0. pwm_q is 0.
- pwm_q registers pwm each rising edge. This half-cycle offset is the only synchronisation; no synchroniser is added. All logic below uses pwm_q.
- Pulse width equals the number of rising edges at which pwm_q = 1. A pulse high for k generator cycles measures k.
- FSM states:
  - IDLE: wait for pwm_q = 0, then go to LOW with gapCnt = 1 and armed = 0. A pulse in progress at reset release is never reported.
  - LOW: gapCnt++ while pwm_q = 0. When pwm_q = 1, go to HIGH with hiCnt = 1 and latch gapCnt into gapHold.
  - HIGH: hiCnt++ while pwm_q = 1. When pwm_q = 0, go to LOW with gapCnt = 1 and emit a pulse report.
- Pulse report, registered one edge after the state leaves HIGH:
  - pulseLen <= hiCnt and pulseGap <= gapHold.
  - pulseValid = 1 only if armed = 1, then armed <= 1. The first pulse after reset has an undefined gap, but pulseLen is still loaded; pulseValid stays 0 for it.
  - shortPulse = pulseValid & (minMask != 0) & (hiCnt < {4'd0, minMask}).
- Latency: for the first rising edge N that samples pwm low, pulseValid is high from edge N+1 to edge N+2.
- Counters hiCnt, gapCnt, winHighSum accumulator and levelCnt saturate at all-ones and never wrap. The window pulse counter saturates at all-ones.
- Window accumulators:
  - acc adds 1 on each cycle with pwm_q = 1. cnt adds 1 per pulse report, counted whether or not armed.
  - On winLast: winHighSum <= acc + (pwm_q ? 1 : 0); winPulseCnt <= cnt + (report this cycle ? 1 : 0); winValid = 1.
  - Accumulators then restart at 0, so the boundary cycle belongs to the ending window.
  - A pulse report coincident with winLast counts in the ending window. A pulse spanning the boundary counts in the window where it ends; its high cycles are split between windows.
- Stuck detection:
  - levelCnt counts consecutive equal pwm_q samples, independent of FSM state, and resets to 1 on each level change.
  - stuckHigh = (stuckMax != 0) & pwm_q & (levelCnt >= stuckMax); stuckLow likewise for pwm_q = 0.
  - Both are registered and deassert on the edge after the level changes.
- Changing m3r_* mid-operation takes effect on the next compare; no restart.
- rst asserted mid-pulse clears everything immediately and asynchronously. No partial report is made.

Decomposition:
- Shared package motoro3_pkg holds the FSM state typedef (IDLE, LOW, HIGH) and the CW/PCW defaults. The PWM generator reuses the same constants.
- One natural sub-module, motoro3_sat_counter: a saturating CW-bit counter with clear and load-1, used for hiCnt, gapCnt, acc and levelCnt.

Test Plan:
- Reset release with pwm low, then pulses of 32 high / 100 low, twice → first report pulseLen = 32 with pulseValid = 0; second report pulseLen = 32, pulseGap = 100, pulseValid = 1, shortPulse = 0.
- minMask = 256, pulse of 100 cycles after an armed pulse → pulseValid = 1, shortPulse = 1, errSticky = 1 and stays set. minMask = 0 with the same pulse → shortPulse = 0.
- Window with pulses of 10, 20, 30 cycles, winLast on the cycle the third pulse's report fires → winHighSum = 60, winPulseCnt = 3, winValid for one cycle. Next window starts at 0.
- stuckMax = 1000, pwm held high 1500 cycles → stuckHigh rises after the 1000th high sample and drops one edge after pwm falls. stuckMax = 0 → never asserts.
- pwm held high 70000 cycles then dropped → pulseLen = 0xFFFF (saturated), no wrap.
- rst pulsed mid-pulse (hiCnt = 50) → all outputs 0, FSM in IDLE. The remaining high portion is not reported, and the next full pulse reports with pulseValid = 0 (unarmed).

Source files
------------

// File: rtl/motoro3_pwm_monitor_pkg.sv
// motoro3_pkg: constants and FSM state shared by the motor PWM generator and monitor
package motoro3_pkg;
   localparam int CW_DEF  = 16;
   localparam int PCW_DEF = 8;
   typedef enum logic [1:0] {IDLE, LOW, HIGH} pwmState_e;
endpackage

// File: rtl/motoro3_pwm_monitor_sat_counter.sv
// motoro3_sat_counter: CW-bit up counter that holds at all-ones, with clear and load-1
module motoro3_sat_counter
   import motoro3_pkg::*;
#(
   parameter int CW = CW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          ld1,
   input  logic          inc,
   output logic [CW-1:0] cnt
);
   always_ff @(posedge clk or posedge rst)
      if (rst) cnt <= '0;
      else if (clr) cnt <= '0;
      else if (ld1) cnt <= CW'(1);
      else if (inc && (cnt != '1)) cnt <= cnt + CW'(1);
endmodule

// File: rtl/motoro3_pwm_monitor.sv
// motoro3_pwm_monitor: measures PWM pulse width/gap, per-window totals and short/stuck faults
module motoro3_pwm_monitor
   import motoro3_pkg::*;
#(
   parameter int CW  = CW_DEF,
   parameter int PCW = PCW_DEF
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           pwm,
   input  logic           winLast,
   input  logic [11:0]    m3r_pwmMinMask,
   input  logic [CW-1:0]  m3r_stuckMax,
   output logic [CW-1:0]  pulseLen,
   output logic [CW-1:0]  pulseGap,
   output logic           pulseValid,
   output logic           shortPulse,
   output logic [CW-1:0]  winHighSum,
   output logic [PCW-1:0] winPulseCnt,
   output logic           winValid,
   output logic           stuckHigh,
   output logic           stuckLow,
   output logic           errSticky
);
   pwmState_e state, stateNext;
   logic pwmQ, pwmQd, qLive, armed;
   logic rep, enterLow, enterHigh, hiInc, gapInc, shortNext;
   logic [CW-1:0] hiCnt, gapCnt, gapHold, acc, levelCnt, accSum;
   logic [PCW-1:0] winCnt, cntSum;

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= stateNext;

   // the first pwmQ after reset is the reset value, not a sample, so IDLE ignores it
   always_comb stateNext = (state == IDLE) ? ((qLive && !pwmQ) ? LOW : IDLE) : (pwmQ ? HIGH : LOW);

   always_comb begin
      rep       = (state == HIGH) && !pwmQ;
      enterHigh = (state == LOW) && pwmQ;
      enterLow  = (state != LOW) && (stateNext == LOW);
      hiInc     = (state == HIGH) && pwmQ;
      gapInc    = (state == LOW) && !pwmQ;
   end

   motoro3_sat_counter #(.CW(CW)) uHiCnt (.clk(clk), .rst(rst), .clr(1'b0), .ld1(enterHigh), .inc(hiInc), .cnt(hiCnt));
   motoro3_sat_counter #(.CW(CW)) uGapCnt (.clk(clk), .rst(rst), .clr(1'b0), .ld1(enterLow), .inc(gapInc), .cnt(gapCnt));
   motoro3_sat_counter #(.CW(CW)) uAcc (.clk(clk), .rst(rst), .clr(winLast), .ld1(1'b0), .inc(pwmQ), .cnt(acc));
   motoro3_sat_counter #(.CW(CW)) uLevelCnt (.clk(clk), .rst(rst), .clr(1'b0), .ld1(pwmQ != pwmQd), .inc(1'b1), .cnt(levelCnt));

   // pwmQd is the level of the run levelCnt is counting, so the stuck flags decode registers only
   always_comb begin
      accSum    = acc + CW'(pwmQ && (acc != '1));
      cntSum    = winCnt + PCW'(rep && (winCnt != '1));
      shortNext = rep && armed && (m3r_pwmMinMask != '0) && (hiCnt < CW'(m3r_pwmMinMask));
      stuckHigh = (m3r_stuckMax != '0) && pwmQd && (levelCnt >= m3r_stuckMax);
      stuckLow  = (m3r_stuckMax != '0) && !pwmQd && (levelCnt >= m3r_stuckMax);
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         pwmQ        <= 1'b0;
         pwmQd       <= 1'b0;
         qLive       <= 1'b0;
         armed       <= 1'b0;
         gapHold     <= '0;
         pulseLen    <= '0;
         pulseGap    <= '0;
         pulseValid  <= 1'b0;
         shortPulse  <= 1'b0;
         winCnt      <= '0;
         winHighSum  <= '0;
         winPulseCnt <= '0;
         winValid    <= 1'b0;
         errSticky   <= 1'b0;
      end else begin
         pwmQ  <= pwm;
         pwmQd <= pwmQ;
         qLive <= 1'b1;
         if (enterHigh) gapHold <= gapCnt;
         if (rep) begin
            pulseLen <= hiCnt;
            pulseGap <= gapHold;
            armed    <= 1'b1;
         end
         pulseValid <= rep && armed;
         shortPulse <= shortNext;
         winCnt     <= winLast ? '0 : cntSum;
         if (winLast) begin
            winHighSum  <= accSum;
            winPulseCnt <= cntSum;
         end
         winValid  <= winLast;
         errSticky <= errSticky || shortNext || stuckHigh || stuckLow;
      end
endmodule

// File: tb/tb_motoro3_pwm_monitor.sv
// tb_motoro3_pwm_monitor: run-length reference model plus directed pulse scenarios
`timescale 1ns/1ps
module tb_motoro3_pwm_monitor;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic pwm = 1'b0;
   logic winLast = 1'b0;
   logic [11:0] m3r_pwmMinMask = '0;
   logic [15:0] m3r_stuckMax = '0;
   logic [15:0] pulseLen, pulseGap, winHighSum;
   logic [7:0] winPulseCnt;
   logic pulseValid, shortPulse, winValid, stuckHigh, stuckLow, errSticky;
   int tests = 0;
   int fails = 0;

   motoro3_pwm_monitor dut (
      .clk(clk), .rst(rst), .pwm(pwm), .winLast(winLast),
      .m3r_pwmMinMask(m3r_pwmMinMask), .m3r_stuckMax(m3r_stuckMax),
      .pulseLen(pulseLen), .pulseGap(pulseGap), .pulseValid(pulseValid), .shortPulse(shortPulse),
      .winHighSum(winHighSum), .winPulseCnt(winPulseCnt), .winValid(winValid),
      .stuckHigh(stuckHigh), .stuckLow(stuckLow), .errSticky(errSticky)
   );

   always #50 clk = ~clk;

   // reference model: tracks runs of sampled levels rather than FSM states
   int mq = 0, live = 0, runLvl = 0, run = 0, hiLen = 0, lowLen = 0, gapSnap = 0;
   int elig = 0, seenLow = 0, armedM = 0, acc = 0, cnt = 0;
   logic [15:0] eLen = '0, eGap = '0, eSum = '0;
   logic [7:0] eCnt = '0;
   logic eValid = 1'b0, eShort = 1'b0, eWin = 1'b0, eErr = 1'b0;

   function automatic int sat(input int v, input int m);
      return (v > m) ? m : v;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mq = 0; live = 0; runLvl = 0; run = 0; hiLen = 0; lowLen = 0; gapSnap = 0;
         elig = 0; seenLow = 0; armedM = 0; acc = 0; cnt = 0;
         eLen = '0; eGap = '0; eSum = '0; eCnt = '0;
         eValid = 1'b0; eShort = 1'b0; eWin = 1'b0; eErr = 1'b0;
      end else begin : mdl
         int s, rep;
         s = mq;
         rep = 0;
         eErr = eErr | ((m3r_stuckMax != 0) && (run >= int'(m3r_stuckMax)));
         eValid = 1'b0;
         eShort = 1'b0;
         if (live != 0) begin
            if (s != 0) begin
               if (hiLen == 0) begin
                  gapSnap = lowLen;
                  elig = seenLow;
               end
               hiLen = sat(hiLen + 1, 65535);
               lowLen = 0;
            end else begin
               if (hiLen > 0 && elig != 0) begin
                  rep = 1;
                  eLen = 16'(hiLen);
                  eGap = 16'(gapSnap);
                  eValid = (armedM != 0);
                  armedM = 1;
                  eShort = eValid && (m3r_pwmMinMask != 0) && (hiLen < int'(m3r_pwmMinMask));
               end
               hiLen = 0;
               lowLen = sat(lowLen + 1, 65535);
               seenLow = 1;
            end
         end
         live = 1;
         eErr = eErr | eShort;
         if (s == runLvl) run = sat(run + 1, 65535);
         else begin
            runLvl = s;
            run = 1;
         end
         eWin = winLast;
         if (winLast) begin
            eSum = 16'(sat(acc + s, 65535));
            eCnt = 8'(sat(cnt + rep, 255));
            acc = 0;
            cnt = 0;
         end else begin
            acc = sat(acc + s, 65535);
            cnt = sat(cnt + rep, 255);
         end
         mq = int'(pwm);
      end
   end

   always @(posedge clk) begin
      #1;
      if (!rst) begin : cmp
         logic eSH, eSL;
         logic [61:0] act, expv;
         eSH = (m3r_stuckMax != 0) && (runLvl == 1) && (run >= int'(m3r_stuckMax));
         eSL = (m3r_stuckMax != 0) && (runLvl == 0) && (run >= int'(m3r_stuckMax));
         act = {pulseLen, pulseGap, pulseValid, shortPulse, winHighSum, winPulseCnt, winValid, stuckHigh, stuckLow, errSticky};
         expv = {eLen, eGap, eValid, eShort, eSum, eCnt, eWin, eSH, eSL, eErr};
         tests++;
         if (act !== expv) begin
            fails++;
            if (fails < 20) $display("FAIL model t=%0t got %h want %h", $time, act, expv);
         end
      end
   end

   task automatic chk(input string nm, input int act, input int want);
      tests++;
      if (act !== want) begin
         fails++;
         $display("FAIL %s: got %0h want %0h", nm, act, want);
      end
   endtask

   task automatic drive(input logic lvl, input int n);
      for (int i = 0; i < n; i++) begin
         pwm = lvl;
         @(negedge clk);
      end
   endtask

   task automatic chkAllZero(input string nm);
      chk(nm, int'(|{pulseLen, pulseGap, pulseValid, shortPulse, winHighSum, winPulseCnt, winValid, stuckHigh, stuckLow, errSticky}), 0);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chkAllZero("reset_outputs");
      rst = 1'b0;
      drive(0, 10);
      drive(1, 32); drive(0, 2);
      chk("first_len", int'(pulseLen), 32);
      chk("first_valid", int'(pulseValid), 0);
      drive(0, 98);
      drive(1, 32); drive(0, 2);
      chk("second_len", int'(pulseLen), 32);
      chk("second_gap", int'(pulseGap), 100);
      chk("second_valid", int'(pulseValid), 1);
      chk("second_short", int'(shortPulse), 0);
      drive(0, 98);
      m3r_pwmMinMask = 12'd256;
      drive(1, 100); drive(0, 2);
      chk("short_valid", int'(pulseValid), 1);
      chk("short_flag", int'(shortPulse), 1);
      chk("short_err", int'(errSticky), 1);
      drive(0, 20);
      chk("err_held", int'(errSticky), 1);
      m3r_pwmMinMask = 12'd0;
      drive(1, 100); drive(0, 2);
      chk("mask0_short", int'(shortPulse), 0);
      drive(0, 20);
      m3r_pwmMinMask = 12'd100;
      drive(1, 100); drive(0, 2);
      chk("mask_eq_short", int'(shortPulse), 0);
      chk("mask_eq_valid", int'(pulseValid), 1);
      drive(0, 20);
      m3r_pwmMinMask = 12'd0;
      winLast = 1'b1; drive(0, 1); winLast = 1'b0;
      chk("win0_sum", int'(winHighSum), 364);
      chk("win0_cnt", int'(winPulseCnt), 5);
      chk("win0_valid", int'(winValid), 1);
      drive(0, 1);
      chk("win0_strobe", int'(winValid), 0);
      drive(0, 4);
      drive(1, 10); drive(0, 5);
      drive(1, 20); drive(0, 5);
      drive(1, 30); drive(0, 1);
      winLast = 1'b1; drive(0, 1); winLast = 1'b0;
      chk("win1_sum", int'(winHighSum), 60);
      chk("win1_cnt", int'(winPulseCnt), 3);
      chk("win1_valid", int'(winValid), 1);
      chk("win1_pulse", int'(pulseLen), 30);
      drive(0, 3);
      winLast = 1'b1; drive(0, 1); winLast = 1'b0;
      chk("win2_sum", int'(winHighSum), 0);
      chk("win2_cnt", int'(winPulseCnt), 0);
      m3r_stuckMax = 16'd1000;
      drive(1, 1000);
      chk("stuck_999", int'(stuckHigh), 0);
      drive(1, 1);
      chk("stuck_1000", int'(stuckHigh), 1);
      drive(1, 499); drive(0, 1);
      chk("stuck_hold", int'(stuckHigh), 1);
      drive(0, 1);
      chk("stuck_drop", int'(stuckHigh), 0);
      chk("stuck_len", int'(pulseLen), 1500);
      m3r_stuckMax = 16'd0;
      drive(1, 1500);
      chk("stuck_off", int'(stuckHigh), 0);
      drive(0, 20);
      m3r_stuckMax = 16'd50;
      drive(0, 40);
      chk("stuck_low", int'(stuckLow), 1);
      m3r_stuckMax = 16'd0;
      drive(1, 70000); drive(0, 2);
      chk("sat_len", int'(pulseLen), 65535);
      drive(0, 20);
      drive(1, 51);
      rst = 1'b1;
      #1;
      chkAllZero("midpulse_reset");
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      drive(1, 30); drive(0, 2);
      chk("partial_len", int'(pulseLen), 0);
      chk("partial_valid", int'(pulseValid), 0);
      drive(0, 8);
      drive(1, 40); drive(0, 2);
      chk("post_reset_len", int'(pulseLen), 40);
      chk("post_reset_valid", int'(pulseValid), 0);
      chk("post_reset_err", int'(errSticky), 0);
      drive(0, 5);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
